// File: rtl/red_seq_pkg.sv
// Shared types and widths for the sequential RED unit.
// Optional build macro RED_SEQ_PREFETCH_EN is consumed in red_seq.sv.
package red_seq_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned UP_W   = 9;
    localparam int unsigned FIN_W  = 12;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        U0   = 4'd1,
        U1   = 4'd2,
        L0   = 4'd3,
        L1   = 4'd4,
        F0   = 4'd5,
        F1   = 4'd6,
        F2   = 4'd7,
        DONE = 4'd8
    } state_e;

endpackage

// File: rtl/red_seq_if.sv
// Valid/ready operand and result channel of the sequential RED unit.
interface red_seq_if;
    import red_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] Out;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Out
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Out
    );

endinterface

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder with optional subtract and unsigned saturation.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    input  logic       sat,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] b_eff;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        b_eff = b ^ {4{sub}};
        g     = a & b_eff;
        p     = a ^ b_eff;
        c[0]  = cin | sub;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
        cout  = c[4];
        sum   = p ^ c[3:0];
        // Add overflows on carry-out, subtract underflows on missing carry-out.
        if (sat && (sub ? !c[4] : c[4])) begin
            sum = sub ? 4'h0 : 4'hF;
        end
    end

endmodule

// File: rtl/red_seq.sv
// Multi-cycle RED unit: one shared cla_4bit stepped over seven nibble slices.
// Build macro RED_SEQ_PREFETCH_EN adds a one-entry operand buffer that accepts in any state.
module red_seq
    import red_seq_pkg::*;
#(
    parameter bit BACKPRESSURE = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    red_seq_if.slave bus
);

    state_e             state_q, state_d;
    logic               pend_valid_q, pend_valid_d;
    logic [DATA_W-1:0]  pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
    logic [UP_W-1:0]    up9_q, up9_d, lo9_q, lo9_d;
    logic [FIN_W-1:0]   f12_q, f12_d;
    logic               carry_q, carry_d;

    logic [FIN_W-1:0]   up12, lo12;
    logic [NIB_W-1:0]   nib_a, nib_b, sum;
    logic               cout;
    logic               accept, retire, take;

    // The pending register doubles as the accept-cycle latch when prefetch is off,
    // which is what puts U0 one cycle after the accepting edge.
`ifdef RED_SEQ_PREFETCH_EN
    assign bus.in_ready = !pend_valid_q;
`else
    assign bus.in_ready = (state_q == IDLE) && !pend_valid_q;
`endif

    assign accept        = bus.in_valid && bus.in_ready;
    assign retire        = (state_q == DONE) && (BACKPRESSURE ? bus.out_ready : 1'b1);
    assign take          = pend_valid_q && ((state_q == IDLE) || retire);
    assign bus.out_valid = (state_q == DONE);
    assign bus.Out       = {{(DATA_W - FIN_W){f12_q[FIN_W-1]}}, f12_q};

    assign up12 = {{(FIN_W - UP_W){up9_q[UP_W-1]}}, up9_q};
    assign lo12 = {{(FIN_W - UP_W){lo9_q[UP_W-1]}}, lo9_q};

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        unique case (state_q)
            U0:      begin nib_a = a_q[11:8];   nib_b = b_q[11:8];   end
            U1:      begin nib_a = a_q[15:12];  nib_b = b_q[15:12];  end
            L0:      begin nib_a = a_q[3:0];    nib_b = b_q[3:0];    end
            L1:      begin nib_a = a_q[7:4];    nib_b = b_q[7:4];    end
            F0:      begin nib_a = up12[3:0];   nib_b = lo12[3:0];   end
            F1:      begin nib_a = up12[7:4];   nib_b = lo12[7:4];   end
            F2:      begin nib_a = up12[11:8];  nib_b = lo12[11:8];  end
            default: ;
        endcase
    end

    cla_4bit u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sub  (1'b0),
        .sat  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pend_valid_q) state_d = U0;
            U0:      state_d = U1;
            U1:      state_d = L0;
            L0:      state_d = L1;
            L1:      state_d = F0;
            F0:      state_d = F1;
            F1:      state_d = F2;
            F2:      state_d = DONE;
            DONE:    if (retire) state_d = pend_valid_q ? U0 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pend_valid_d = accept || (pend_valid_q && !take);
        pend_a_d     = accept ? bus.A : pend_a_q;
        pend_b_d     = accept ? bus.B : pend_b_q;
        a_d          = take ? pend_a_q : a_q;
        b_d          = take ? pend_b_q : b_q;
        carry_d      = ((state_d == U0) || (state_d == L0) || (state_d == F0)) ? 1'b0 : cout;
        up9_d        = up9_q;
        lo9_d        = lo9_q;
        f12_d        = f12_q;
        unique case (state_q)
            U0:      up9_d[3:0]  = sum;
            U1:      up9_d[8:4]  = {cout, sum};
            L0:      lo9_d[3:0]  = sum;
            L1:      lo9_d[8:4]  = {cout, sum};
            F0:      f12_d[3:0]  = sum;
            F1:      f12_d[7:4]  = sum;
            F2:      f12_d[11:8] = sum;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_valid_q <= 1'b0;
            pend_a_q     <= '0;
            pend_b_q     <= '0;
            a_q          <= '0;
            b_q          <= '0;
            up9_q        <= '0;
            lo9_q        <= '0;
            f12_q        <= '0;
            carry_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_a_q     <= pend_a_d;
            pend_b_q     <= pend_b_d;
            a_q          <= a_d;
            b_q          <= b_d;
            up9_q        <= up9_d;
            lo9_q        <= lo9_d;
            f12_q        <= f12_d;
            carry_q      <= carry_d;
        end
    end

endmodule

// File: tb/tb_red_seq.sv
// Scoreboard bench for red_seq: golden model results queued on accept, compared on retire.
module tb_red_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    red_seq_if bus ();

    red_seq #(.BACKPRESSURE(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic [15:0] exp_q[$];
    int          acc_q[$];
    bit          seen_valid = 1'b0;
    bit          prev_hold  = 1'b0;
    logic [15:0] prev_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
        int up, lo, f;
        up = int'(a[15:8]) + int'(b[15:8]);
        lo = int'(a[7:0]) + int'(b[7:0]);
        if (up >= 256) up -= 512;
        if (lo >= 256) lo -= 512;
        f = (up + lo) & 'hFFF;
        if (f >= 2048) f -= 4096;
        return 16'(f);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change 1 time unit after posedge, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            seen_valid = 1'b0;
            prev_hold  = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_out", 32'(bus.Out), 32'(prev_out));
            end
            if (bus.out_valid && !seen_valid) begin
                seen_valid = 1'b1;
                if (acc_q.size() > 0) check("latency", 32'(cyc - acc_q[0]), 32'd8);
                else check("unexpected_valid", 32'(bus.out_valid), 32'd0);
            end
            if (bus.out_valid && bus.out_ready) begin
                seen_valid = 1'b0;
                if (exp_q.size() > 0) begin
                    check("out", 32'(bus.Out), 32'(exp_q.pop_front()));
                    void'(acc_q.pop_front());
                end
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_out  = bus.Out;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.A, bus.B));
                acc_q.push_back(cyc + 1);
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("accept_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.A         = '0;
        bus.B         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out", 32'(bus.Out), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed corner cases.
        send(16'h0101, 16'h0101);
        drain();
        send(16'hFFFF, 16'hFFFF);
        drain();
        send(16'h8000, 16'h8000);
        drain();
        send(16'h000F, 16'h0001);
        drain();
        check("dir_expect_4", 32'(model(16'h0101, 16'h0101)), 32'h0004);

        // Back-to-back random operands.
        for (int i = 0; i < 8; i++) begin
            send(16'($urandom), 16'($urandom));
        end
        drain();

        // Backpressure: result held while out_ready is low, new operands refused.
        bus.out_ready = 1'b0;
        send(16'h1234, 16'h4321);
        for (int i = 0; i < 20 && !bus.out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        check("bp_valid", 32'(bus.out_valid), 32'd1);
        bus.A        = 16'hFFFF;
        bus.B        = 16'h7777;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // Reset mid-operation (during F0) discards the op.
        send(16'h1111, 16'h2222);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) check("midrst_no_result", 32'(bus.out_valid), 32'd0);
        end
        send(16'h0202, 16'h0000);
        drain();
        check("final_in_ready", 32'(bus.in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
